// File: rtl/rc4_prga_if.sv
// Bus bundle between the RC4 PRGA block and its S memory, encrypted ROM and
// decrypted RAM, plus the start/done handshake with the top-level controller.
interface rc4_prga_if #(
    parameter int ADDR_W = 5
) ();
    logic              start;
    logic              done;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [ADDR_W-1:0] ram_address;
    logic [7:0]        ram_data;
    logic              ram_wren;

    modport master (
        input  start, s_q, rom_q,
        output done, s_address, s_data, s_wren, rom_address,
               ram_address, ram_data, ram_wren
    );

    modport slave (
        output start, s_q, rom_q,
        input  done, s_address, s_data, s_wren, rom_address,
               ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA over a preloaded S memory: XORs each keystream byte with one
// encrypted ROM byte and writes the plaintext to RAM, 12 cycles per byte.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic       clk,
    input  logic       reset,
    rc4_prga_if.master bus
);
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] RD_I  = 4'd1;
    localparam logic [3:0] WT_I  = 4'd2;
    localparam logic [3:0] CAP_I = 4'd3;
    localparam logic [3:0] RD_J  = 4'd4;
    localparam logic [3:0] WT_J  = 4'd5;
    localparam logic [3:0] CAP_J = 4'd6;
    localparam logic [3:0] WR_I  = 4'd7;
    localparam logic [3:0] WR_J  = 4'd8;
    localparam logic [3:0] RD_F  = 4'd9;
    localparam logic [3:0] WT_F  = 4'd10;
    localparam logic [3:0] CAP_F = 4'd11;
    localparam logic [3:0] WR_O  = 4'd12;
    localparam logic [3:0] DONE  = 4'd13;

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

    logic [3:0]        state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [7:0]        si_q, si_d, sj_q, sj_d, f_q, f_d, e_q, e_d;

    logic              done_q, done_d;
    logic [7:0]        s_address_q, s_address_d, s_data_q, s_data_d;
    logic              s_wren_q, s_wren_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;

    // Sequencer and RC4 index/value registers.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        e_d     = e_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = RD_I;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_I:  state_d = WT_I;
            WT_I:  state_d = CAP_I;
            CAP_I: begin
                si_d    = bus.s_q;
                j_d     = j_q + bus.s_q;
                state_d = RD_J;
            end
            RD_J:  state_d = WT_J;
            WT_J:  state_d = CAP_J;
            CAP_J: begin
                sj_d    = bus.s_q;
                state_d = WR_I;
            end
            WR_I:  state_d = WR_J;
            WR_J:  state_d = RD_F;
            RD_F:  state_d = WT_F;
            WT_F:  state_d = CAP_F;
            CAP_F: begin
                f_d     = bus.s_q;
                e_d     = bus.rom_q;
                state_d = WR_O;
            end
            WR_O: begin
                if (k_q == LAST_K) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + ADDR_W'(1);
                    i_d     = i_q + 8'd1;
                    state_d = RD_I;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up
    // with the state they belong to.
    always_comb begin
        done_d        = 1'b0;
        s_address_d   = 8'd0;
        s_data_d      = 8'd0;
        s_wren_d      = 1'b0;
        rom_address_d = '0;
        ram_address_d = '0;
        ram_data_d    = 8'd0;
        ram_wren_d    = 1'b0;
        case (state_d)
            RD_I, WT_I, CAP_I: s_address_d = i_d;
            RD_J, WT_J, CAP_J: s_address_d = j_d;
            WR_I: begin
                s_address_d = i_d;
                s_data_d    = sj_d;
                s_wren_d    = 1'b1;
            end
            WR_J: begin
                s_address_d = j_d;
                s_data_d    = si_d;
                s_wren_d    = 1'b1;
            end
            RD_F, WT_F, CAP_F: begin
                s_address_d   = si_d + sj_d;
                rom_address_d = k_d;
            end
            WR_O: begin
                ram_address_d = k_d;
                ram_data_d    = f_d ^ e_d;
                ram_wren_d    = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // State, datapath and output registers; reset aborts any run at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            i_q           <= 8'd0;
            j_q           <= 8'd0;
            k_q           <= '0;
            si_q          <= 8'd0;
            sj_q          <= 8'd0;
            f_q           <= 8'd0;
            e_q           <= 8'd0;
            done_q        <= 1'b0;
            s_address_q   <= 8'd0;
            s_data_q      <= 8'd0;
            s_wren_q      <= 1'b0;
            rom_address_q <= '0;
            ram_address_q <= '0;
            ram_data_q    <= 8'd0;
            ram_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            si_q          <= si_d;
            sj_q          <= sj_d;
            f_q           <= f_d;
            e_q           <= e_d;
            done_q        <= done_d;
            s_address_q   <= s_address_d;
            s_data_q      <= s_data_d;
            s_wren_q      <= s_wren_d;
            rom_address_q <= rom_address_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

    assign bus.done        = done_q;
    assign bus.s_address   = s_address_q;
    assign bus.s_data      = s_data_q;
    assign bus.s_wren      = s_wren_q;
    assign bus.rom_address = rom_address_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_wren    = ram_wren_q;
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: synchronous memory models, a software RC4
// reference, a table of hand-derived bytes and multi-cycle corner sequences.
module tb_rc4_prga_decrypt;
    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;
    localparam int LAT     = 12 * MSG_LEN + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rc4_prga_if #(.ADDR_W(ADDR_W)) bus ();
    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] smem   [256];
    logic [7:0] s_init [256];
    logic [7:0] rom    [MSG_LEN];
    logic [7:0] ram_img[MSG_LEN];
    logic [7:0] exp_ram[MSG_LEN];
    logic [7:0] s_log_a[8];
    logic [7:0] s_log_d[8];
    logic       load_s, clr, order_err;
    int         s_wr_cnt, ram_wr_cnt;
    int         n_vec = 0;
    int         n_err = 0;

    // Synchronous S memory and ROM.
    always @(posedge clk) begin
        if (load_s) begin
            for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
        end else if (bus.s_wren) begin
            smem[bus.s_address] <= bus.s_data;
        end
        bus.s_q   <= smem[bus.s_address];
        bus.rom_q <= rom[bus.rom_address];
    end

    // RAM image and write accounting.
    always @(posedge clk) begin
        if (clr) begin
            s_wr_cnt   <= 0;
            ram_wr_cnt <= 0;
            order_err  <= 1'b0;
            for (int a = 0; a < MSG_LEN; a++) ram_img[a] <= 8'h00;
        end else begin
            if (bus.s_wren) begin
                if (s_wr_cnt < 8) begin
                    s_log_a[s_wr_cnt] <= bus.s_address;
                    s_log_d[s_wr_cnt] <= bus.s_data;
                end
                s_wr_cnt <= s_wr_cnt + 1;
            end
            if (bus.ram_wren) begin
                ram_img[bus.ram_address] <= bus.ram_data;
                if (int'(bus.ram_address) != ram_wr_cnt) order_err <= 1'b1;
                ram_wr_cnt <= ram_wr_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Textbook RC4 PRGA on a copy of the initial S box.
    task automatic model_run();
        logic [7:0] s[256];
        int i = 0, j = 0, t;
        for (int a = 0; a < 256; a++) s[a] = s_init[a];
        for (int k = 0; k < MSG_LEN; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = int'(s[i]); s[i] = s[j]; s[j] = 8'(t);
            exp_ram[k] = s[(int'(s[i]) + int'(s[j])) % 256] ^ rom[k];
        end
    endtask

    // s_mode: 0 identity, 1 zeros, 2 KSA key 000249, 3 random permutation.
    // enc_mode: 0 zeros, 1 enc[k]=k, 2 0x41 at 0 else 0, 3 random.
    task automatic prep(input int s_mode, input int enc_mode);
        logic [7:0] key[3];
        int j = 0, y;
        logic [7:0] t;
        key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
        for (int a = 0; a < 256; a++) s_init[a] = (s_mode == 1) ? 8'h00 : 8'(a);
        if (s_mode == 2) begin
            for (int a = 0; a < 256; a++) begin
                j = (j + int'(s_init[a]) + int'(key[a % 3])) % 256;
                t = s_init[a]; s_init[a] = s_init[j]; s_init[j] = t;
            end
        end else if (s_mode == 3) begin
            for (int a = 255; a > 0; a--) begin
                y = int'($urandom_range(a, 0));
                t = s_init[a]; s_init[a] = s_init[y]; s_init[y] = t;
            end
        end
        for (int k = 0; k < MSG_LEN; k++) begin
            case (enc_mode)
                1:       rom[k] = 8'(k);
                2:       rom[k] = (k == 0) ? 8'h41 : 8'h00;
                3:       rom[k] = 8'($urandom);
                default: rom[k] = 8'h00;
            endcase
        end
        model_run();
    endtask

    task automatic load_mem();
        @(negedge clk);
        load_s = 1'b1; clr = 1'b1;
        @(negedge clk);
        load_s = 1'b0; clr = 1'b0;
    endtask

    // One full run; hold keeps start high to the end, otherwise start is a
    // short pulse with a stray re-pulse mid-run that must be ignored.
    task automatic do_run(input bit hold);
        int lat = 0;
        load_mem();
        bus.start = 1'b1;
        for (int n = 1; n <= LAT + 50; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("first_i", 64'(bus.s_address), 64'd1);
                if (!hold) bus.start = 1'b0;
            end
            if (n == 4) chk("first_j", 64'(bus.s_address), 64'(s_init[1]));
            if (!hold && n == 100) bus.start = 1'b1;
            if (!hold && n == 101) bus.start = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        chk("done_latency", 64'(lat), 64'(LAT));
        chk("s_wr_count", 64'(s_wr_cnt), 64'(2 * MSG_LEN));
        chk("ram_wr_count", 64'(ram_wr_cnt), 64'(MSG_LEN));
        chk("ram_order", 64'(order_err), 64'd0);
        for (int k = 0; k < MSG_LEN; k++) chk("ram_byte", 64'(ram_img[k]), 64'(exp_ram[k]));
    endtask

    typedef struct {
        int         s_mode;
        int         enc_mode;
        int         k;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[9];
    int   cur_s, cur_e, snap_s, snap_r;
    bit   ok;

    initial begin
        tbl[0] = '{0, 0, 0,  8'h02};
        tbl[1] = '{0, 0, 1,  8'h05};
        tbl[2] = '{0, 0, 2,  8'h07};
        tbl[3] = '{0, 2, 0,  8'h43};
        tbl[4] = '{0, 2, 1,  8'h05};
        tbl[5] = '{1, 1, 0,  8'h00};
        tbl[6] = '{1, 1, 5,  8'h05};
        tbl[7] = '{1, 1, 17, 8'h11};
        tbl[8] = '{1, 1, 31, 8'h1F};

        reset = 1'b1; bus.start = 1'b0; load_s = 1'b0; clr = 1'b1;
        for (int a = 0; a < 256; a++) s_init[a] = 8'h00;
        for (int k = 0; k < MSG_LEN; k++) rom[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'd0, bus.done, bus.s_wren, bus.ram_wren, bus.s_address,
            bus.s_data, bus.rom_address, bus.ram_address, bus.ram_data}, 64'd0);
        reset = 1'b0; clr = 1'b0;
        @(negedge clk);

        cur_s = -1; cur_e = -1;
        for (int v = 0; v < 9; v++) begin
            if (tbl[v].s_mode != cur_s || tbl[v].enc_mode != cur_e) begin
                cur_s = tbl[v].s_mode; cur_e = tbl[v].enc_mode;
                prep(cur_s, cur_e);
                do_run(1'b0);
            end
            chk("table_byte", 64'(ram_img[tbl[v].k]), 64'(tbl[v].exp));
        end

        // Identity S: i==j swap leaves S alone, then byte 1 swaps s[2]/s[3].
        prep(0, 0);
        do_run(1'b0);
        chk("swap0_addr", {s_log_a[0], s_log_d[0], s_log_a[1], s_log_d[1]}, 64'h01010101);
        chk("swap1_i", {s_log_a[2], s_log_d[2]}, 64'h0203);
        chk("swap1_j", {s_log_a[3], s_log_d[3]}, 64'h0302);

        for (int r = 0; r < 3; r++) begin
            prep(3, 3);
            do_run(1'b0);
        end

        // Asynchronous reset 20 cycles into a run, then a clean restart.
        prep(3, 3);
        load_mem();
        bus.start = 1'b1;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("abort_outputs", {27'd0, bus.done, bus.s_wren, bus.ram_wren, bus.s_address,
            bus.s_data, bus.rom_address, bus.ram_address, bus.ram_data}, 64'd0);
        bus.start = 1'b0;
        snap_s = s_wr_cnt; snap_r = ram_wr_cnt;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_no_writes", {32'(s_wr_cnt), 32'(ram_wr_cnt)}, {32'(snap_s), 32'(snap_r)});
        chk("abort_done_low", 64'(bus.done), 64'd0);
        do_run(1'b0);

        // KSA-derived S with start held high through DONE.
        prep(2, 3);
        do_run(1'b1);
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.done !== 1'b1) ok = 1'b0;
        end
        chk("hold_done", 64'(ok), 64'd1);
        chk("hold_no_rerun", {32'(s_wr_cnt), 32'(ram_wr_cnt)}, {32'(2 * MSG_LEN), 32'(MSG_LEN)});
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_drop", 64'(bus.done), 64'd0);
        do_run(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
